// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the J17 datapath. Latches the 32-bit
//   instruction in FETCH, exposes its decoded fields, and steps through
//   DECODE / EXEC / MEM / WB, issuing control strobes for the ALU, data
//   RAM, register file and PC. MUL waits on alu_done and LOAD/STORE wait
//   on mem_ready, each bounded by a timeout.
//
// Ports
//   clock        in   rising-edge system clock
//   reset        in   asynchronous, active-high
//   instruction  in   [31:0] instruction word, sampled at the end of FETCH
//   alu_done     in   multiplier result valid (looked at only in EXEC/MUL)
//   mem_ready    in   RAM access complete (looked at only in MEM)
//   zero_flag    in   ALU compare result for BEQ
//   opcode       out  [5:0]  IR[31:26]
//   op1          out  [4:0]  IR[25:21]
//   op2          out  [4:0]  IR[20:16]
//   imm          out  [15:0] IR[15:0]
//   ir_load      out  latch instruction
//   alu_op       out  [1:0]  0=ADD 1=SUB 2=MUL 3=CMP
//   alu_start    out  pulse on the first EXEC cycle
//   ram_read     out  held in MEM for LOAD
//   ram_write    out  held in MEM for STORE
//   reg_write    out  register-file write enable (WB)
//   pc_inc       out  PC <= PC + 1
//   pc_load      out  PC <= imm
//   illegal      out  pulse in DECODE on an undefined opcode
//   timeout      out  sticky handshake-timeout flag
//   halted       out  sticky halt flag
module multicycle_sequencer #(
  parameter int MUL_TIMEOUT = 16,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_done,
  input  logic        mem_ready,
  input  logic        zero_flag,
  output logic [5:0]  opcode,
  output logic [4:0]  op1,
  output logic [4:0]  op2,
  output logic [15:0] imm,
  output logic        ir_load,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  output logic        ram_read,
  output logic        ram_write,
  output logic        reg_write,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        illegal,
  output logic        timeout,
  output logic        halted
);

  localparam int TMAX  = (MUL_TIMEOUT > MEM_TIMEOUT) ? MUL_TIMEOUT : MEM_TIMEOUT;
  localparam int CNT_W = $clog2(TMAX + 1);

  // Last wait cycle index: the counter starts at 0 on state entry, so the
  // N-th waiting cycle is index N-1.
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_MUL   = 6'd2;
  localparam logic [5:0] OP_LOAD  = 6'd3;
  localparam logic [5:0] OP_STORE = 6'd4;
  localparam logic [5:0] OP_JMP   = 6'd5;
  localparam logic [5:0] OP_BEQ   = 6'd6;
  localparam logic [5:0] OP_HALT  = 6'd63;

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [31:0]      ir;
  logic [CNT_W-1:0] cnt;
  logic             ready;        // low during the first cycle after reset release
  logic             timeout_hit;

  assign opcode = ir[31:26];
  assign op1    = ir[25:21];
  assign op2    = ir[20:16];
  assign imm    = ir[15:0];

  // Strobes are decoded from state + IR. Reset forces state to FETCH with
  // ready low, so every strobe falls as soon as reset rises.
  always_comb begin
    next_state  = state;
    ir_load     = 1'b0;
    alu_op      = 2'd0;
    alu_start   = 1'b0;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    reg_write   = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    illegal     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_FETCH: begin
        if (ready) begin
          ir_load    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_MUL, OP_BEQ, OP_JMP: next_state = S_EXEC;
          OP_LOAD, OP_STORE:                      next_state = S_MEM;
          OP_HALT:                                next_state = S_HALT;
          default: begin
            illegal    = 1'b1;
            pc_inc     = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        alu_start = (cnt == '0);
        case (opcode)
          OP_ADD: begin
            alu_op     = 2'd0;
            next_state = S_WB;
          end
          OP_SUB: begin
            alu_op     = 2'd1;
            next_state = S_WB;
          end
          OP_MUL: begin
            alu_op = 2'd2;
            if (alu_done) begin
              next_state = S_WB;
            end else if (cnt == MUL_LAST) begin
              // Multiplier never answered: skip the instruction, no WB.
              timeout_hit = 1'b1;
              pc_inc      = 1'b1;
              next_state  = S_FETCH;
            end
          end
          OP_JMP: begin
            pc_load    = 1'b1;
            next_state = S_FETCH;
          end
          OP_BEQ: begin
            alu_op     = 2'd3;
            pc_load    = zero_flag;
            pc_inc     = ~zero_flag;
            next_state = S_FETCH;
          end
          default: next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          // The access strobe stays up through the completing cycle.
          if (opcode == OP_LOAD) begin
            ram_read   = 1'b1;
            next_state = S_WB;
          end else begin
            ram_write  = 1'b1;
            pc_inc     = 1'b1;
            next_state = S_FETCH;
          end
        end else if (cnt == MEM_LAST) begin
          timeout_hit = 1'b1;
          pc_inc      = 1'b1;
          next_state  = S_FETCH;
        end else begin
          ram_read  = (opcode == OP_LOAD);
          ram_write = (opcode == OP_STORE);
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_inc     = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      ir      <= '0;
      cnt     <= '0;
      ready   <= 1'b0;
      timeout <= 1'b0;
      halted  <= 1'b0;
    end else begin
      ready <= 1'b1;
      state <= next_state;
      if (ir_load)
        ir <= instruction;
      // Wait counter restarts on every state change and saturates otherwise.
      if (next_state != state)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
      if (timeout_hit)
        timeout <= 1'b1;
      if (next_state == S_HALT)
        halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer
//   Directed testbench for multicycle_sequencer. Each task walks one
//   instruction cycle by cycle and compares the strobe vector against a
//   hand-derived expected sequence.
module tb_multicycle_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic        alu_done = 1'b0;
  logic        mem_ready = 1'b0;
  logic        zero_flag = 1'b0;
  logic [5:0]  opcode;
  logic [4:0]  op1;
  logic [4:0]  op2;
  logic [15:0] imm;
  logic        ir_load, alu_start, ram_read, ram_write, reg_write;
  logic        pc_inc, pc_load, illegal, timeout, halted;
  logic [1:0]  alu_op;

  multicycle_sequencer #(.MUL_TIMEOUT(16), .MEM_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .alu_done(alu_done), .mem_ready(mem_ready), .zero_flag(zero_flag),
    .opcode(opcode), .op1(op1), .op2(op2), .imm(imm),
    .ir_load(ir_load), .alu_op(alu_op), .alu_start(alu_start),
    .ram_read(ram_read), .ram_write(ram_write), .reg_write(reg_write),
    .pc_inc(pc_inc), .pc_load(pc_load), .illegal(illegal),
    .timeout(timeout), .halted(halted)
  );

  always #5 clock = ~clock;

  // Strobe vector bit order: ir_load alu_start ram_read ram_write
  //                          reg_write pc_inc pc_load illegal
  logic [7:0] strobes;
  assign strobes = {ir_load, alu_start, ram_read, ram_write,
                    reg_write, pc_inc, pc_load, illegal};

  localparam logic [7:0] IRL = 8'h80;
  localparam logic [7:0] AST = 8'h40;
  localparam logic [7:0] RR  = 8'h20;
  localparam logic [7:0] RW  = 8'h10;
  localparam logic [7:0] RGW = 8'h08;
  localparam logic [7:0] PCI = 8'h04;
  localparam logic [7:0] PCL = 8'h02;
  localparam logic [7:0] ILL = 8'h01;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (strobes !== 8'h00) begin
      n_bad++; $display("FAIL reset_strobes got %b want %b", strobes, 8'h00);
    end
    n_cmp++;
    if ({timeout, halted, opcode, op1, op2, imm} !== 34'h0) begin
      n_bad++; $display("FAIL reset_regs got t=%b h=%b ir=%h want all 0", timeout, halted, {opcode, op1, op2, imm});
    end
    step;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (strobes !== 8'h00) begin
      n_bad++; $display("FAIL post_release_strobes got %b want %b", strobes, 8'h00);
    end
    step;
    n_cmp++;
    if (strobes !== IRL) begin
      n_bad++; $display("FAIL first_fetch got %b want %b", strobes, IRL);
    end
  endtask

  task automatic test_add;
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      instruction = (i == 0) ? 32'h00220000 : 32'hDEADBEEF;
      #1;
      case (i)
        0: exp = IRL;
        1: exp = 8'h00;
        2: exp = AST;
        3: exp = RGW | PCI;
        default: exp = IRL;
      endcase
      n_cmp++;
      if (strobes !== exp) begin
        n_bad++; $display("FAIL add cyc%0d got %b want %b", i, strobes, exp);
      end
      if (i == 1) begin
        n_cmp++;
        if ({opcode, op1, op2, imm} !== {6'd0, 5'd1, 5'd2, 16'h0000}) begin
          n_bad++; $display("FAIL add_fields got %h/%h/%h/%h want 0/1/2/0", opcode, op1, op2, imm);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (alu_op !== 2'd0) begin
          n_bad++; $display("FAIL add_alu_op got %0d want 0", alu_op);
        end
      end
      if (i < 4) step;
    end
  endtask

  task automatic test_mul_done;
    logic [7:0] exp;
    int writes;
    writes = 0;
    for (int i = 0; i < 7; i++) begin
      instruction = 32'h08640000;
      alu_done = (i == 4);
      #1;
      case (i)
        0, 6: exp = IRL;
        2: exp = AST;
        5: exp = RGW | PCI;
        default: exp = 8'h00;
      endcase
      n_cmp++;
      if (strobes !== exp) begin
        n_bad++; $display("FAIL mul cyc%0d got %b want %b", i, strobes, exp);
      end
      if (i == 3) begin
        n_cmp++;
        if (alu_op !== 2'd2) begin
          n_bad++; $display("FAIL mul_alu_op got %0d want 2", alu_op);
        end
      end
      if (reg_write === 1'b1) writes++;
      if (i < 6) step;
    end
    alu_done = 1'b0;
    n_cmp++;
    if (writes !== 1) begin
      n_bad++; $display("FAIL mul_reg_write_count got %0d want 1", writes);
    end
  endtask

  task automatic test_load;
    logic [7:0] exp;
    for (int i = 0; i < 6; i++) begin
      instruction = 32'h0CA00010;
      mem_ready = (i == 1) || (i == 3);
      #1;
      case (i)
        0, 5: exp = IRL;
        1: exp = 8'h00;
        2, 3: exp = RR;
        default: exp = RGW | PCI;
      endcase
      n_cmp++;
      if (strobes !== exp) begin
        n_bad++; $display("FAIL load cyc%0d got %b want %b", i, strobes, exp);
      end
      if (i < 5) step;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_store;
    logic [7:0] exp;
    for (int i = 0; i < 6; i++) begin
      instruction = 32'h10C00020;
      mem_ready = (i == 4);
      #1;
      case (i)
        0, 5: exp = IRL;
        1: exp = 8'h00;
        2, 3: exp = RW;
        default: exp = RW | PCI;
      endcase
      n_cmp++;
      if (strobes !== exp) begin
        n_bad++; $display("FAIL store cyc%0d got %b want %b", i, strobes, exp);
      end
      if (i < 5) step;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_branch(input logic zf);
    logic [7:0] exp;
    zero_flag = zf;
    for (int i = 0; i < 4; i++) begin
      instruction = 32'h18220004;
      #1;
      case (i)
        0, 3: exp = IRL;
        1: exp = 8'h00;
        default: exp = zf ? (AST | PCL) : (AST | PCI);
      endcase
      n_cmp++;
      if (strobes !== exp) begin
        n_bad++; $display("FAIL beq_z%0d cyc%0d got %b want %b", zf, i, strobes, exp);
      end
      if (i == 2) begin
        n_cmp++;
        if (alu_op !== 2'd3) begin
          n_bad++; $display("FAIL beq_alu_op got %0d want 3", alu_op);
        end
      end
      if (i < 3) step;
    end
    zero_flag = 1'b0;
  endtask

  task automatic test_jmp;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      instruction = 32'h14000040;
      #1;
      case (i)
        0, 3: exp = IRL;
        1: exp = 8'h00;
        default: exp = PCL;
      endcase
      // alu_start is not part of the jump's contract; mask it out.
      n_cmp++;
      if ((strobes & ~AST) !== exp) begin
        n_bad++; $display("FAIL jmp cyc%0d got %b want %b", i, strobes & ~AST, exp);
      end
      if (i < 3) step;
    end
  endtask

  task automatic test_illegal;
    logic [7:0] exp;
    for (int i = 0; i < 3; i++) begin
      instruction = 32'h80000000;
      #1;
      exp = (i == 1) ? (ILL | PCI) : IRL;
      n_cmp++;
      if (strobes !== exp) begin
        n_bad++; $display("FAIL illegal cyc%0d got %b want %b", i, strobes, exp);
      end
      if (i < 2) step;
    end
  endtask

  task automatic test_mul_timeout;
    logic [7:0] exp;
    int writes;
    writes = 0;
    for (int i = 0; i < 19; i++) begin
      instruction = 32'h08640000;
      #1;
      if (i == 0 || i == 18) exp = IRL;
      else if (i == 2) exp = AST;
      else if (i == 17) exp = PCI;
      else exp = 8'h00;
      n_cmp++;
      if (strobes !== exp) begin
        n_bad++; $display("FAIL mul_to cyc%0d got %b want %b", i, strobes, exp);
      end
      if (i == 17) begin
        n_cmp++;
        if (timeout !== 1'b0) begin
          n_bad++; $display("FAIL mul_to_early got %b want 0", timeout);
        end
      end
      if (reg_write === 1'b1) writes++;
      if (i < 18) step;
    end
    n_cmp++;
    if (timeout !== 1'b1 || writes !== 0) begin
      n_bad++; $display("FAIL mul_to_flag got t=%b writes=%0d want t=1 writes=0", timeout, writes);
    end
  endtask

  task automatic test_reset_mid_mem;
    logic [7:0] exp;
    for (int i = 0; i < 3; i++) begin
      instruction = 32'h10C00020;
      #1;
      case (i)
        0: exp = IRL;
        1: exp = 8'h00;
        default: exp = RW;
      endcase
      n_cmp++;
      if (strobes !== exp) begin
        n_bad++; $display("FAIL rst_mem cyc%0d got %b want %b", i, strobes, exp);
      end
      if (i < 2) step;
    end
    // Assert reset between clock edges: the write strobe must drop at once.
    reset = 1'b1;
    #1;
    n_cmp++;
    if (strobes !== 8'h00 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL rst_async got %b t=%b want 00000000 t=0", strobes, timeout);
    end
    step;
    n_cmp++;
    if (strobes !== 8'h00) begin
      n_bad++; $display("FAIL rst_held got %b want %b", strobes, 8'h00);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (strobes !== 8'h00) begin
      n_bad++; $display("FAIL rst_release got %b want %b", strobes, 8'h00);
    end
    step;
    n_cmp++;
    if (strobes !== IRL) begin
      n_bad++; $display("FAIL rst_refetch got %b want %b", strobes, IRL);
    end
  endtask

  task automatic test_mem_timeout;
    logic [7:0] exp;
    for (int i = 0; i < 19; i++) begin
      instruction = 32'h0CA00010;
      #1;
      if (i == 0 || i == 18) exp = IRL;
      else if (i == 1) exp = 8'h00;
      else if (i == 17) exp = PCI;
      else exp = RR;
      n_cmp++;
      if (strobes !== exp) begin
        n_bad++; $display("FAIL mem_to cyc%0d got %b want %b", i, strobes, exp);
      end
      if (i < 18) step;
    end
    n_cmp++;
    if (timeout !== 1'b1) begin
      n_bad++; $display("FAIL mem_to_flag got %b want 1", timeout);
    end
  endtask

  task automatic test_halt;
    for (int i = 0; i < 22; i++) begin
      instruction = 32'hFC000000;
      alu_done  = (i > 5);
      mem_ready = (i > 5);
      #1;
      if (i == 0) begin
        n_cmp++;
        if (strobes !== IRL) begin
          n_bad++; $display("FAIL halt_fetch got %b want %b", strobes, IRL);
        end
      end else if (i == 1) begin
        n_cmp++;
        if (strobes !== 8'h00 || halted !== 1'b0) begin
          n_bad++; $display("FAIL halt_decode got %b h=%b want 00000000 h=0", strobes, halted);
        end
      end else begin
        n_cmp++;
        if (strobes !== 8'h00 || halted !== 1'b1) begin
          n_bad++; $display("FAIL halt cyc%0d got %b h=%b want 00000000 h=1", i, strobes, halted);
        end
      end
      step;
    end
    alu_done  = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_add;
    test_mul_done;
    test_load;
    test_store;
    test_branch(1'b1);
    test_branch(1'b0);
    test_jmp;
    test_illegal;
    test_mul_timeout;
    test_reset_mid_mem;
    test_mem_timeout;
    test_halt;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
